// File: rtl/axi_ram_slave.sv
// AXI4-style single-port-per-direction RAM slave: INCR bursts of 32-bit words with
// independent read and write state machines sharing one word-addressed memory.
module axi_ram_slave #(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned INIT_ZERO = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  // Read address / data
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // Write address / data / response
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {RIdle, RLoad, RBurst} r_state_e;
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

  // Time-zero contents only; reset never touches the array.
  logic [31:0] mem_q [Depth] = '{default: (INIT_ZERO != 0) ? 32'h0000_0000 : 32'hxxxx_xxxx};

  // Holds the address channels closed until the first clock edge after reset release.
  logic out_en_q;

  r_state_e             r_state_q, r_state_d;
  logic [3:0]           r_id_q, r_id_d;
  logic [ADDR_BITS-1:0] r_addr_q, r_addr_d, r_addr_nxt;
  logic [7:0]           r_cnt_q, r_cnt_d;
  logic [31:0]          rdata_q, rdata_d;

  w_state_e             w_state_q, w_state_d;
  logic [3:0]           w_id_q, w_id_d;
  logic [ADDR_BITS-1:0] w_addr_q, w_addr_d;
  logic [7:0]           w_cnt_q, w_cnt_d;
  logic                 w_err_q, w_err_d;

  logic mem_we;

  logic unused_addr;
  assign unused_addr = ^{araddr[31:ADDR_BITS+2], araddr[1:0],
                         awaddr[31:ADDR_BITS+2], awaddr[1:0]};

  // ---------------------------------------------------------------- state registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_en_q  <= 1'b0;
      r_state_q <= RIdle;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_cnt_q   <= '0;
      rdata_q   <= '0;
      w_state_q <= WIdle;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
    end else begin
      out_en_q  <= 1'b1;
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_cnt_q   <= r_cnt_d;
      rdata_q   <= rdata_d;
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
    end
  end

  // Non-blocking write makes a same-cycle read load see the old word.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem_q[w_addr_q][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- read next state
  assign r_addr_nxt = r_addr_q + 1'b1;

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_cnt_d   = r_cnt_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      RIdle: begin
        if (arvalid && arready) begin
          r_id_d    = arid;
          r_addr_d  = araddr[ADDR_BITS+1:2];
          r_cnt_d   = arlen;
          r_state_d = RLoad;
        end
      end
      RLoad: begin
        rdata_d   = mem_q[r_addr_q];
        r_state_d = RBurst;
      end
      RBurst: begin
        if (rready) begin
          if (r_cnt_q != 8'd0) begin
            r_addr_d = r_addr_nxt;
            r_cnt_d  = r_cnt_q - 8'd1;
            rdata_d  = mem_q[r_addr_nxt];
          end else begin
            r_state_d = RIdle;
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  // ---------------------------------------------------------------- read outputs
  always_comb begin
    arready = out_en_q && (r_state_q == RIdle);
    rvalid  = (r_state_q == RBurst);
    rlast   = rvalid && (r_cnt_q == 8'd0);
    rresp   = 2'b00;
    rid     = r_id_q;
    rdata   = rdata_q;
  end

  // ---------------------------------------------------------------- write next state
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    unique case (w_state_q)
      WIdle: begin
        if (awvalid && awready) begin
          w_id_d    = awid;
          w_addr_d  = awaddr[ADDR_BITS+1:2];
          w_cnt_d   = awlen;
          w_err_d   = 1'b0;
          w_state_d = WData;
        end
      end
      WData: begin
        if (wvalid) begin
          w_addr_d = w_addr_q + 1'b1;
          w_cnt_d  = w_cnt_q - 8'd1;
          // Whichever of wlast / length exhaustion comes first ends the burst.
          if (wlast || (w_cnt_q == 8'd0)) begin
            w_err_d   = wlast != (w_cnt_q == 8'd0);
            w_state_d = WResp;
          end
        end
      end
      WResp: begin
        if (bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  // ---------------------------------------------------------------- write outputs
  always_comb begin
    awready = out_en_q && (w_state_q == WIdle);
    wready  = (w_state_q == WData);
    bvalid  = (w_state_q == WResp);
    bresp   = (bvalid && w_err_q) ? 2'b10 : 2'b00;
    bid     = w_id_q;
    mem_we  = wready && wvalid;
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed self-checking bench for axi_ram_slave: bursts, strobes, stalls, length
// mismatches, address wrap/aliasing and asynchronous reset in the middle of bursts.
module tb_axi_ram_slave;

  logic        aclk;
  logic        aresetn;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  axi_ram_slave #(
    .ADDR_BITS(12),
    .INIT_ZERO(1)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .arid    (arid),
    .araddr  (araddr),
    .arlen   (arlen),
    .arvalid (arvalid),
    .arready (arready),
    .rid     (rid),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready),
    .awid    (awid),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bid     (bid),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Beat b carries base + step*b; last_beat < 0 means wlast is never raised.
  task automatic axi_write(input string tag, input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input int nbeats, input int last_beat,
                           input logic [3:0] strb, input logic [31:0] base,
                           input logic [31:0] step, input logic [1:0] exp_resp);
    for (int k = 0; k < 20 && awready !== 1'b1; k++) tick();
    check({tag, ".awready"}, awready, 1);
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check({tag, ".awready_busy"}, awready, 0);
    for (int b = 0; b < nbeats; b++) begin
      wdata = base + step * b; wstrb = strb; wlast = (b == last_beat); wvalid = 1'b1;
      for (int k = 0; k < 20 && wready !== 1'b1; k++) tick();
      check({tag, ".wready"}, wready, 1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    for (int k = 0; k < 20 && bvalid !== 1'b1; k++) tick();
    check({tag, ".bvalid"}, bvalid, 1);
    check({tag, ".wready_off"}, wready, 0);
    check({tag, ".bid"}, bid, id);
    check({tag, ".bresp"}, bresp, exp_resp);
    tick();
    bready = 1'b0;
    check({tag, ".bvalid_off"}, bvalid, 0);
  endtask

  // Expects beat i to return base + step*i; stall drops rready every other cycle.
  task automatic axi_read(input string tag, input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [31:0] base,
                          input logic [31:0] step, input bit stall);
    logic [31:0] exp;
    for (int k = 0; k < 20 && arready !== 1'b1; k++) tick();
    check({tag, ".arready"}, arready, 1);
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check({tag, ".arready_busy"}, arready, 0);
    rready = !stall;
    for (int i = 0; i <= int'(len); i++) begin
      exp = base + step * i;
      for (int k = 0; k < 20 && rvalid !== 1'b1; k++) tick();
      if (stall) begin
        rready = 1'b0;
        tick();
        check({tag, ".stall_rvalid"}, rvalid, 1);
        check({tag, ".stall_rdata"}, rdata, exp);
        rready = 1'b1;
      end
      check({tag, ".rvalid"}, rvalid, 1);
      check({tag, ".rdata"}, rdata, exp);
      check({tag, ".rlast"}, rlast, (i == int'(len)) ? 1 : 0);
      check({tag, ".rid"}, rid, id);
      check({tag, ".rresp"}, rresp, 0);
      tick();
    end
    rready = 1'b0;
    check({tag, ".rvalid_off"}, rvalid, 0);
  endtask

  initial begin
    aresetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    #1;
    check("rst.arready", arready, 0);
    check("rst.awready", awready, 0);
    check("rst.wready", wready, 0);
    check("rst.rvalid", rvalid, 0);
    check("rst.bvalid", bvalid, 0);
    check("rst.rdata", rdata, 0);
    check("rst.ids_resps", {rid, bid, rresp, bresp, rlast}, 0);
    repeat (2) tick();
    aresetn = 1'b1;
    check("rel.arready_pre_edge", arready, 0);
    tick();
    check("rel.arready", arready, 1);
    check("rel.awready", awready, 1);

    // Basic 4-beat burst write and readback
    axi_write("wr100", 4'h5, 32'h100, 8'd3, 4, 3, 4'hF, 32'h11, 32'h11, 2'b00);
    axi_read("rd100", 4'h9, 32'h100, 8'd3, 32'h11, 32'h11, 1'b0);

    // 16-beat burst read with rready toggling
    axi_write("wr400", 4'h1, 32'h400, 8'd15, 16, 15, 4'hF, 32'h1000, 32'h1, 2'b00);
    axi_read("rd400_stall", 4'h2, 32'h400, 8'd15, 32'h1000, 32'h1, 1'b1);

    // Byte strobes
    axi_write("wr200_full", 4'h3, 32'h200, 8'd0, 1, 0, 4'hF, 32'hAABB_CCDD, 32'h0, 2'b00);
    axi_write("wr200_strb", 4'h4, 32'h200, 8'd0, 1, 0, 4'b0101, 32'h1122_3344, 32'h0, 2'b00);
    axi_read("rd200", 4'h6, 32'h200, 8'd0, 32'hAA22_CC44, 32'h0, 1'b0);

    // Early wlast and missing wlast both end the burst with SLVERR
    axi_read("rd304_zero", 4'h7, 32'h304, 8'd0, 32'h0, 32'h0, 1'b0);
    axi_write("wr300_early", 4'hA, 32'h300, 8'd1, 1, 0, 4'hF, 32'hDEAD_0001, 32'h0, 2'b10);
    axi_read("rd300", 4'hB, 32'h300, 8'd0, 32'hDEAD_0001, 32'h0, 1'b0);
    axi_read("rd304_still_zero", 4'hB, 32'h304, 8'd0, 32'h0, 32'h0, 1'b0);
    axi_write("wr304_nolast", 4'hC, 32'h304, 8'd0, 1, -1, 4'hF, 32'h0BAD_0002, 32'h0, 2'b10);
    axi_read("rd304", 4'hD, 32'h304, 8'd0, 32'h0BAD_0002, 32'h0, 1'b0);

    // Word address wrap inside a burst, and aliasing of upper address bits
    axi_write("wr_wrap", 4'hE, 32'h3FFC, 8'd1, 2, 1, 4'hF, 32'hA0, 32'h1, 2'b00);
    axi_read("rd_wrap", 4'hF, 32'h3FFC, 8'd1, 32'hA0, 32'h1, 1'b0);
    axi_read("rd_alias", 4'h8, 32'h4100, 8'd0, 32'h11, 32'h0, 1'b0);

    // Reset during beat 2 of an 8-beat read
    arid = 4'h3; araddr = 32'h400; arlen = 8'd7; arvalid = 1'b1;
    tick();
    arvalid = 1'b0; rready = 1'b1;
    for (int k = 0; k < 20 && rvalid !== 1'b1; k++) tick();
    check("rstrd.beat1", rdata, 32'h1000);
    tick();
    check("rstrd.beat2", rdata, 32'h1001);
    #2 aresetn = 1'b0;
    #1;
    check("rstrd.rvalid", rvalid, 0);
    check("rstrd.rdata", rdata, 0);
    check("rstrd.rid_rlast", {rid, rlast}, 0);
    check("rstrd.arready", arready, 0);
    rready = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
    check("rstrd.arready_back", arready, 1);

    // Reset during a 4-beat write after one beat
    awid = 4'h6; awaddr = 32'h500; awlen = 8'd3; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wdata = 32'h5000; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    check("rstwr.wready_on", wready, 1);
    tick();
    wvalid = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    check("rstwr.wready", wready, 0);
    check("rstwr.bvalid", bvalid, 0);
    check("rstwr.bid", bid, 0);
    check("rstwr.awready", awready, 0);
    tick();
    aresetn = 1'b1;
    tick();
    check("rstwr.awready_back", awready, 1);
    check("rstwr.arready_back", arready, 1);

    // Fresh traffic after reset and memory retention
    axi_write("wr600", 4'h2, 32'h600, 8'd1, 2, 1, 4'hF, 32'h6000, 32'h1, 2'b00);
    axi_read("rd600", 4'h2, 32'h600, 8'd1, 32'h6000, 32'h1, 1'b0);
    axi_read("rd100_kept", 4'h1, 32'h100, 8'd3, 32'h11, 32'h11, 1'b0);
    axi_read("rd200_kept", 4'h1, 32'h200, 8'd0, 32'hAA22_CC44, 32'h0, 1'b0);
    axi_read("rd500_kept", 4'h1, 32'h500, 8'd0, 32'h5000, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
